// File: rtl/pipe_add_sub.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES registered chunks with a valid/ready stream.
// Optional build macro PIPE_ADD_SAT_EN clamps overflowing results to the signed limit that matches A's sign.
module pipe_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_add_sub: STAGES must be 1..WIDTH and divide WIDTH");
  end

  function automatic logic signed_ovf(input logic a_msb, input logic bp_msb, input logic s_msb);
    return (a_msb == bp_msb) && (s_msb != a_msb);
  endfunction

`ifdef PIPE_ADD_SAT_EN
  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH-1:0] s,
                                                       input logic ov, input logic a_msb);
    logic signed [WIDTH-1:0] lim;
    lim = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return ov ? lim : s;
  endfunction
`endif

  // The whole pipe moves as one shift register; a full output slot blocks every stage.
  logic adv;
  assign adv      = !g_stage[LAST].g_tail.vld_q || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * CHUNK;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]      a_in;
    logic [REM-1:0]      bp_in;
    logic                cin;
    logic                vld_in;
    logic [CHUNK:0]      part;
    logic [LO+CHUNK-1:0] sum_acc;

    // Operands still waiting for their chunk arrive on skew registers; finished low sums on deskew registers.
    if (k == 0) begin : g_head
      assign a_in    = a;
      assign bp_in   = sub ? ~b : b;
      assign cin     = sub;
      assign vld_in  = in_valid;
      assign sum_acc = part[CHUNK-1:0];
    end else begin : g_link
      assign a_in    = g_stage[k-1].g_mid.a_q;
      assign bp_in   = g_stage[k-1].g_mid.bp_q;
      assign cin     = g_stage[k-1].g_mid.cy_q;
      assign vld_in  = g_stage[k-1].g_mid.vld_q;
      assign sum_acc = {part[CHUNK-1:0], g_stage[k-1].g_mid.sum_q};
    end

    assign part = {1'b0, a_in[CHUNK-1:0]} + {1'b0, bp_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, cin};

    if (k < LAST) begin : g_mid
      logic [REM-CHUNK-1:0] a_q;
      logic [REM-CHUNK-1:0] bp_q;
      logic [LO+CHUNK-1:0]  sum_q;
      logic                 cy_q;
      logic                 vld_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= 1'b0;
        end else if (adv) begin
          vld_q <= vld_in;
        end
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          a_q   <= a_in[REM-1:CHUNK];
          bp_q  <= bp_in[REM-1:CHUNK];
          sum_q <= sum_acc;
          cy_q  <= part[CHUNK];
        end
      end
    end else begin : g_tail
      logic             ov;
      logic [WIDTH-1:0] res;
      logic [WIDTH-1:0] c_q;
      logic             cy_q;
      logic             ovf_q;
      logic             zero_q;
      logic             vld_q;

      assign ov = signed_ovf(a_in[CHUNK-1], bp_in[CHUNK-1], part[CHUNK-1]);
`ifdef PIPE_ADD_SAT_EN
      assign res = saturate(sum_acc, ov, a_in[CHUNK-1]);
`else
      assign res = sum_acc;
`endif

      // Final stage: full result, flags and zero detect all land in the output registers.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q  <= 1'b0;
          c_q    <= '0;
          cy_q   <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          vld_q  <= vld_in;
          c_q    <= res;
          cy_q   <= part[CHUNK];
          ovf_q  <= ov;
          zero_q <= (res == '0);
        end
      end

      assign out_valid = vld_q;
      assign c         = c_q;
      assign carry     = cy_q;
      assign ovf       = ovf_q;
      assign zero      = zero_q;
    end
  end

endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench for pipe_add_sub: directed cases on a STAGES=2 instance, then randomized traffic on STAGES 2/1/4/32.
// Expected values come from a plain-integer arithmetic model; honours PIPE_ADD_SAT_EN like the design.
module tb_pipe_add_sub;

  localparam int NI = 4;

  function automatic int stg(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      2:       return 4;
      default: return 32;
    endcase
  endfunction

  typedef struct packed {
    logic [31:0] c;
    logic        cy;
    logic        ov;
    logic        z;
    logic [31:0] acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_ready_v  [NI];
  logic        out_valid_v [NI];
  logic        carry_v     [NI];
  logic        ovf_v       [NI];
  logic        zero_v      [NI];
  logic [31:0] c_v         [NI];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    pipe_add_sub #(.WIDTH(32), .STAGES(stg(gi))) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[gi]),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid_v[gi]), .out_ready(out_ready),
      .c(c_v[gi]), .carry(carry_v[gi]), .ovf(ovf_v[gi]), .zero(zero_v[gi])
    );
  end

  // Reference: exact integer result, then wrap/saturate and derive flags from it.
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic ms);
    exp_t        r;
    longint      sa, sb, ex;
    logic [63:0] ua, ub, uex;
    sa  = $signed(ma);
    sb  = $signed(mb);
    ua  = {32'd0, ma};
    ub  = {32'd0, mb};
    ex  = ms ? sa - sb : sa + sb;
    uex = ms ? ua - ub : ua + ub;
    r.c   = 32'(ex);
    r.cy  = ms ? (ua >= ub) : uex[32];
    r.ov  = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
`ifdef PIPE_ADD_SAT_EN
    if (r.ov) r.c = (ex < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    r.z   = (r.c == 32'd0);
    r.acc = '0;
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Single op through instance 0 (STAGES=2) with out_ready high; called 1 time unit after a clock edge.
  task automatic op_check(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                          input logic ts, input logic [31:0] ec, input logic ecy,
                          input logic eov, input logic ez);
    in_valid = 1'b1; a = ta; b = tbv; sub = ts; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_early"}, out_valid_v[0], 1'b0);
    @(posedge clk); #1;
    chk({tag, "_vld"},   out_valid_v[0], 1'b1);
    chk({tag, "_c"},     c_v[0],         ec);
    chk({tag, "_carry"}, carry_v[0],     ecy);
    chk({tag, "_ovf"},   ovf_v[0],       eov);
    chk({tag, "_zero"},  zero_v[0],      ez);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    exp_t        e;
    exp_t        e4 [8];
    logic [31:0] a4 [8];
    logic [31:0] b4 [8];
    logic        s4 [8];
    logic [35:0] held;
    logic        stall_prev;
    int          sent, rcv;
    exp_t        q [NI][$];
    int          acc_n [NI];
    int          last_stall [NI];
    logic        prev_pop [NI];
    logic        prev_vld [NI];
    logic        fi [NI];
    int          cyc, drain;
    bit          all_done;

    // Reset state, checked while reset is still asserted
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    #2;
    chk("rst_vld",   out_valid_v[0], 1'b0);
    chk("rst_c",     c_v[0],         32'd0);
    chk("rst_carry", carry_v[0],     1'b0);
    chk("rst_ovf",   ovf_v[0],       1'b0);
    chk("rst_zero",  zero_v[0],      1'b0);
    chk("rst_rdy",   in_ready_v[0],  1'b1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Directed boundary cases
    op_check("chunk_carry", 32'h0000_FFFF, 32'h1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_ADD_SAT_EN
    op_check("pos_ovf",  32'h7FFF_FFFF, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    op_check("neg_ovf",  32'h8000_0000, 32'h1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
    op_check("pos_ovf",  32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    op_check("neg_ovf",  32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
`endif
    op_check("sub_eq",    32'd5,         32'd5, 1'b1, 32'h0,         1'b1, 1'b0, 1'b1);
    op_check("sub_borrow", 32'd0,        32'd1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    op_check("add_wrap",  32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;

    // Eight back-to-back ops with a three-cycle consumer stall
    for (int i = 0; i < 8; i++) begin
      a4[i] = pick(); b4[i] = pick(); s4[i] = 1'($urandom_range(0, 1));
      e4[i] = model(a4[i], b4[i], s4[i]);
    end
    sent = 0; rcv = 0; stall_prev = 1'b0; held = '0;
    for (int t = 0; t < 40 && rcv < 8; t++) begin
      out_ready = !(t >= 4 && t < 7);
      in_valid  = (sent < 8);
      if (sent < 8) begin a = a4[sent]; b = b4[sent]; sub = s4[sent]; end
      #1;
      chk($sformatf("bb_rdy_t%0d", t), in_ready_v[0], !(t >= 4 && t < 7));
      if (stall_prev)
        chk($sformatf("bb_hold_t%0d", t),
            {out_valid_v[0], c_v[0], carry_v[0], ovf_v[0], zero_v[0]}, held);
      stall_prev = out_valid_v[0] && !out_ready;
      if (stall_prev) held = {out_valid_v[0], c_v[0], carry_v[0], ovf_v[0], zero_v[0]};
      if (out_valid_v[0] && out_ready) begin
        chk($sformatf("bb_res%0d", rcv), {c_v[0], carry_v[0], ovf_v[0], zero_v[0]},
            {e4[rcv].c, e4[rcv].cy, e4[rcv].ov, e4[rcv].z});
        rcv++;
      end
      fi[0] = in_valid && in_ready_v[0];
      @(posedge clk);
      if (fi[0]) sent++;
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bb_count", rcv, 8);

    // Asynchronous reset with two ops in flight
    in_valid = 1'b1; a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0;
    @(posedge clk); #1;
    a = 32'h3333_3333; b = 32'h0000_0001; sub = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_vld", out_valid_v[0], 1'b0);
    chk("arst_c",   c_v[0],         32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      chk($sformatf("arst_stale%0d", t), out_valid_v[0], 1'b0);
    end
    e = model(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    op_check("post_rst", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, e.c, e.cy, e.ov, e.z);

    // Randomized traffic on all instances against the model
    rst = 1'b1; in_valid = 1'b0;
    #4 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      acc_n[i] = 0; last_stall[i] = -1; prev_pop[i] = 1'b0; prev_vld[i] = 1'b0;
    end
    cyc = 0; drain = 0;
    for (int it = 0; it < 12000; it++) begin
      all_done = 1'b1;
      for (int i = 0; i < NI; i++) if (acc_n[i] < 1000) all_done = 1'b0;
      if (all_done) drain++;
      if (drain > 40) break;
      a = pick(); b = pick(); sub = 1'($urandom_range(0, 1));
      in_valid  = !all_done && ($urandom_range(0, 4) != 0);
      out_ready = all_done || ((it / 64) % 2 == 1) || ($urandom_range(0, 3) != 0);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (out_valid_v[i] && (prev_pop[i] || !prev_vld[i]) && q[i].size() > 0 &&
            last_stall[i] < int'(q[i][0].acc))
          chk($sformatf("lat_s%0d", stg(i)), cyc - int'(q[i][0].acc) + 1, stg(i));
        fi[i]       = in_valid && in_ready_v[i];
        prev_pop[i] = out_valid_v[i] && out_ready;
        prev_vld[i] = out_valid_v[i];
        if (prev_pop[i]) begin
          if (q[i].size() == 0) begin
            chk($sformatf("extra_s%0d", stg(i)), out_valid_v[i], 1'b0);
          end else begin
            e = q[i].pop_front();
            chk($sformatf("rnd_c_s%0d", stg(i)),     c_v[i],     e.c);
            chk($sformatf("rnd_carry_s%0d", stg(i)), carry_v[i], e.cy);
            chk($sformatf("rnd_ovf_s%0d", stg(i)),   ovf_v[i],   e.ov);
            chk($sformatf("rnd_zero_s%0d", stg(i)),  zero_v[i],  e.z);
          end
        end
        if (out_valid_v[i] && !out_ready) last_stall[i] = cyc + 1;
      end
      @(posedge clk);
      cyc++;
      for (int i = 0; i < NI; i++) begin
        if (fi[i]) begin
          e = model(a, b, sub);
          e.acc = 32'(cyc);
          q[i].push_back(e);
          acc_n[i]++;
        end
      end
      #1;
    end
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rnd_accepts_s%0d", stg(i)), acc_n[i] >= 1000, 1'b1);
      chk($sformatf("rnd_drain_s%0d", stg(i)), q[i].size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
